// File: rtl/serial_comparator_operand_serializer_pkg.sv
// Shared types for the MSB-first serial comparator operand serializer.
package serial_comparator_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_SHIFT = 2'd2
    } state_t;

endpackage

// File: rtl/serial_comparator_operand_serializer_if.sv
// Operand handshake plus serial output bundle; state is exposed for debug/checkers.
interface serial_comparator_operand_serializer_if
    import serial_comparator_pkg::*;
#(
    parameter int W = 16
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         ser_a;
    logic         ser_b;
    logic         ser_valid;
    logic         ser_last;
    logic         cmp_rst;
    state_t       state;

    modport master (
        output in_valid, in_a, in_b,
        input  in_ready, ser_a, ser_b, ser_valid, ser_last, cmp_rst, state
    );

    modport slave (
        input  in_valid, in_a, in_b,
        output in_ready, ser_a, ser_b, ser_valid, ser_last, cmp_rst, state
    );
endinterface

// File: rtl/serial_comparator_operand_serializer_shift_reg.sv
// W-bit shift register that loads in parallel and shifts out MSB first.
module msb_first_shift_reg #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         shift,
    input  logic [W-1:0] load_data,
    output logic         msb
);
    logic [W-1:0] sh;

    // load wins over shift so a back-to-back reload on the last bit is not lost
    always_ff @(posedge clk) begin
        if (rst) begin
            sh <= '0;
        end else if (load) begin
            sh <= load_data;
        end else if (shift) begin
            sh <= {sh[W-2:0], 1'b0};
        end
    end

    assign msb = sh[W-1];
endmodule

// File: rtl/serial_comparator_operand_serializer.sv
// Serializes operand pairs MSB first with a one-cycle comparator clear before each frame.
module serial_comparator_operand_serializer
    import serial_comparator_pkg::*;
#(
    parameter int W = 16
) (
    input logic clk,
    input logic rst,
    serial_comparator_operand_serializer_if.slave bus
);
    localparam int CW = $clog2(W);
    localparam logic [CW-1:0] LAST = CW'(W - 1);

    state_t        state;
    logic [CW-1:0] cnt;
    logic          accept;
    logic          at_last;
    logic          msb_a;
    logic          msb_b;
    logic          shifting;

    // Handshake: a pair transfers on a posedge where in_valid && in_ready; in_ready
    // never depends on in_valid, and upstream holds data while in_ready is low.
    assign at_last      = (state == ST_SHIFT) && (cnt == LAST);
    assign bus.in_ready = !rst && ((state == ST_IDLE) || at_last);
    assign accept       = bus.in_valid && bus.in_ready;
    assign shifting     = (state == ST_SHIFT);

    msb_first_shift_reg #(.W(W)) u_sh_a (
        .clk       (clk),
        .rst       (rst),
        .load      (accept),
        .shift     (shifting),
        .load_data (bus.in_a),
        .msb       (msb_a)
    );

    msb_first_shift_reg #(.W(W)) u_sh_b (
        .clk       (clk),
        .rst       (rst),
        .load      (accept),
        .shift     (shifting),
        .load_data (bus.in_b),
        .msb       (msb_b)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) state <= ST_CLEAR;
                end
                ST_CLEAR: begin
                    cnt   <= '0;
                    state <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    if (cnt == LAST) begin
                        cnt   <= '0;
                        state <= accept ? ST_CLEAR : ST_IDLE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    assign bus.ser_valid = !rst && shifting;
    assign bus.ser_a     = bus.ser_valid && msb_a;
    assign bus.ser_b     = bus.ser_valid && msb_b;
    assign bus.ser_last  = bus.ser_valid && (cnt == LAST);
    assign bus.cmp_rst   = rst || (state == ST_CLEAR);
    assign bus.state     = state;
endmodule

// File: tb/tb_serial_comparator_operand_serializer.sv
// Bench for the operand serializer: vector table, scoreboard queue, reference comparator, W=2 instance.
module tb_serial_comparator_operand_serializer;
    import serial_comparator_pkg::*;

    localparam int W  = 16;
    localparam int EW = 6;
    localparam logic [1:0] REL_EQ = 2'd0;
    localparam logic [1:0] REL_GT = 2'd1;
    localparam logic [1:0] REL_LT = 2'd2;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [1:0]   rel;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;
    logic mon_on = 1'b0;
    logic [1:0] model_rel = REL_EQ;
    // entry: {is_clear, ser_a, ser_b, ser_last, rel[1:0]}
    logic [EW-1:0] exp_q[$];
    vec_t tab[9];

    serial_comparator_operand_serializer_if #(.W(W)) bus ();
    serial_comparator_operand_serializer_if #(.W(2)) bus2 ();

    serial_comparator_operand_serializer #(.W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    serial_comparator_operand_serializer #(.W(2)) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] ref_rel(input logic [W-1:0] a, input logic [W-1:0] b);
        if (a > b) return REL_GT;
        if (a < b) return REL_LT;
        return REL_EQ;
    endfunction

    task automatic push_frame(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [1:0] r;
        r = ref_rel(a, b);
        exp_q.push_back({1'b1, 5'b0});
        for (int i = W - 1; i >= 0; i--) begin
            exp_q.push_back({1'b0, a[i], b[i], (i == 0), (i == 0) ? r : 2'b00});
        end
    endtask

    // churn=1 keeps changing the data while in_ready is low; only the accepted value is expected
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input bit churn);
        int budget;
        budget = 200;
        @(negedge clk); #2;
        bus.in_valid = 1'b1;
        bus.in_a = a;
        bus.in_b = b;
        while (!bus.in_ready && budget > 0) begin
            @(negedge clk); #2;
            budget--;
            if (churn && !bus.in_ready) begin
                bus.in_a = W'($urandom);
                bus.in_b = W'($urandom);
            end
        end
        chk("send_timeout", (budget == 0), 0);
        if (budget > 0) begin
            push_frame(bus.in_a, bus.in_b);
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int budget;
        budget = 200;
        while (exp_q.size() != 0 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        chk("drain_timeout", (budget == 0), 0);
        repeat (2) @(negedge clk);
    endtask

    always @(negedge clk) begin
        logic [EW-1:0] e;
        logic [1:0]    nrel;
        if (mon_on) begin
            if (rst) begin
                chk("rst_cmp_rst", bus.cmp_rst, 1);
                chk("rst_ser_valid", bus.ser_valid, 0);
                chk("rst_ser_last", bus.ser_last, 0);
                chk("rst_in_ready", bus.in_ready, 0);
                chk("rst_ser_bits", {bus.ser_a, bus.ser_b}, 0);
            end else if (bus.cmp_rst || bus.ser_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_output", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    if (e[5]) begin
                        chk("clear_cmp_rst", bus.cmp_rst, 1);
                        chk("clear_ser_valid", bus.ser_valid, 0);
                        chk("clear_in_ready", bus.in_ready, 0);
                        model_rel = REL_EQ;
                    end else begin
                        chk("bit_ser_valid", bus.ser_valid, 1);
                        chk("bit_cmp_rst", bus.cmp_rst, 0);
                        chk("bit_ser_a", bus.ser_a, e[4]);
                        chk("bit_ser_b", bus.ser_b, e[3]);
                        chk("bit_ser_last", bus.ser_last, e[2]);
                        chk("bit_in_ready", bus.in_ready, e[2]);
                        nrel = model_rel;
                        if (model_rel == REL_EQ && bus.ser_a != bus.ser_b)
                            nrel = bus.ser_a ? REL_GT : REL_LT;
                        model_rel = nrel;
                        if (e[2]) chk("frame_result", nrel, e[1:0]);
                    end
                end
            end else if (exp_q.size() != 0) begin
                chk("frame_gap", 1, 0);
            end
        end
    end

    initial begin
        tab[0] = '{16'h6482, 16'h6262, REL_GT};
        tab[1] = '{16'hFFFF, 16'h0000, REL_GT};
        tab[2] = '{16'h1234, 16'h1234, REL_EQ};
        tab[3] = '{16'h0001, 16'h0002, REL_LT};
        tab[4] = '{16'hA5A5, 16'hA5A5, REL_EQ};
        for (int i = 5; i < 9; i++) begin
            tab[i].a = W'($urandom);
            tab[i].b = (i % 2 == 0) ? tab[i].a : W'($urandom);
            tab[i].rel = ref_rel(tab[i].a, tab[i].b);
        end

        bus.in_valid = 1'b0;
        bus.in_a = '0;
        bus.in_b = '0;
        bus2.in_valid = 1'b0;
        bus2.in_a = '0;
        bus2.in_b = '0;

        // reset state
        @(negedge clk);
        mon_on = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_state", bus.state, ST_IDLE);
        chk("rst2_in_ready", bus2.in_ready, 0);
        chk("rst2_cmp_rst", bus2.cmp_rst, 1);
        #2 rst = 1'b0;
        @(negedge clk);
        chk("idle_in_ready", bus.in_ready, 1);
        chk("idle_cmp_rst", bus.cmp_rst, 0);
        chk("idle_ser_valid", bus.ser_valid, 0);
        chk("idle2_in_ready", bus2.in_ready, 1);

        // single isolated frame first, then the rest of the table back-to-back
        for (int i = 0; i < 9; i++) begin
            chk("table_rel", ref_rel(tab[i].a, tab[i].b), tab[i].rel);
            send(tab[i].a, tab[i].b, 1'b0);
            if (i == 0) drain();
        end
        drain();

        // backpressure: request arrives mid-frame with changing data
        send(16'h0F0F, 16'hF0F0, 1'b0);
        repeat (4) @(negedge clk);
        send(W'($urandom), W'($urandom), 1'b1);
        drain();

        // reset at bit 7 of a frame
        send(16'hC3C3, 16'h3C3C, 1'b0);
        repeat (10) @(negedge clk);
        #2;
        rst = 1'b1;
        exp_q.delete();
        @(negedge clk);
        chk("midrst_ser_valid", bus.ser_valid, 0);
        chk("midrst_cmp_rst", bus.cmp_rst, 1);
        chk("midrst_state", bus.state, ST_IDLE);
        #2 rst = 1'b0;
        @(negedge clk); #1;
        chk("postrst_in_ready", bus.in_ready, 1);
        chk("postrst_state", bus.state, ST_IDLE);
        send(16'h8001, 16'h8000, 1'b0);
        drain();

        // W=2 instance: two frames back-to-back, 3 cycles each
        @(negedge clk); #2;
        bus2.in_valid = 1'b1;
        bus2.in_a = 2'b10;
        bus2.in_b = 2'b01;
        @(posedge clk); #1;
        bus2.in_a = 2'b01;
        bus2.in_b = 2'b11;
        @(negedge clk);
        chk("w2_f1_clear", {bus2.cmp_rst, bus2.ser_valid, bus2.in_ready}, 3'b100);
        @(negedge clk);
        chk("w2_f1_bit1", {bus2.ser_valid, bus2.ser_a, bus2.ser_b, bus2.ser_last, bus2.in_ready}, 5'b11000);
        @(negedge clk);
        chk("w2_f1_bit0", {bus2.ser_valid, bus2.ser_a, bus2.ser_b, bus2.ser_last, bus2.in_ready}, 5'b10111);
        @(negedge clk);
        chk("w2_f2_clear", {bus2.cmp_rst, bus2.ser_valid, bus2.in_ready}, 3'b100);
        #2 bus2.in_valid = 1'b0;
        @(negedge clk);
        chk("w2_f2_bit1", {bus2.ser_valid, bus2.ser_a, bus2.ser_b, bus2.ser_last}, 4'b1010);
        @(negedge clk);
        chk("w2_f2_bit0", {bus2.ser_valid, bus2.ser_a, bus2.ser_b, bus2.ser_last}, 4'b1111);
        @(negedge clk);
        chk("w2_idle", {bus2.cmp_rst, bus2.ser_valid, bus2.in_ready}, 3'b001);

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
